// File: rtl/cmd_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_frame_pkg
//  Description : Command codes, operand addresses and FSM state encoding
//                shared by the command frame decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmd_frame_pkg;

    // Command byte values (first byte of every frame)
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file locations of the ALU operands
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // Decoder state encoding
    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_WR_ADDR   = 4'd1;
    localparam state_t ST_WR_DATA   = 4'd2;
    localparam state_t ST_RD_ADDR   = 4'd3;
    localparam state_t ST_ALU_A     = 4'd4;
    localparam state_t ST_ALU_B     = 4'd5;
    localparam state_t ST_ALU_FUN   = 4'd6;
    localparam state_t ST_RD_ISSUE  = 4'd7;
    localparam state_t ST_ALU_ISSUE = 4'd8;

    // First state of the frame opened by a command byte; ST_IDLE means the
    // byte is not a recognised command.
    function automatic state_t cmd_to_state(input logic [7:0] cmd);
        state_t w_st;
        case (cmd)
            CMD_WR:      w_st = ST_WR_ADDR;
            CMD_RD:      w_st = ST_RD_ADDR;
            CMD_ALU_OP:  w_st = ST_ALU_A;
            CMD_ALU_NOP: w_st = ST_ALU_FUN;
            default:     w_st = ST_IDLE;
        endcase
        return w_st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timer
//  Description : Inter-byte timeout counter. Cleared by every received byte,
//                counts while enabled and flags expiry once TIMEOUT_CYC idle
//                cycles have elapsed. Saturates at the limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Idle-cycle counter: clear wins, otherwise count up to the limit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_limit)) begin
            r_count <= r_count + c_one;
        end
    end

    assign expire = enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/cmd_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_frame_decoder
//  Description : Parses command frames from the UART RX byte stream and
//                issues register-file write/read and ALU strobes, plus the
//                ALU clock-gate enable. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_Data,
    input  logic                  RX_D_VLD,
    input  logic                  Resp_Busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_En,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  Gate_En,
    output logic                  Frame_Err
);

    localparam logic [ADDR_WIDTH-1:0] c_opa_addr = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_opb_addr = ADDR_WIDTH'(OPB_ADDR);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [FUN_WIDTH-1:0]  r_fun_hold;

    logic [7:0]            w_cmd;
    logic [ADDR_WIDTH-1:0] w_rx_addr;
    logic [FUN_WIDTH-1:0]  w_rx_fun;
    logic                  w_timer_en;
    logic                  w_expire;

    // Next-cycle values for the registered output stage
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_alu_en;
    logic                  w_gate_en;
    logic                  w_frame_err;
    logic [ADDR_WIDTH-1:0] w_address;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [FUN_WIDTH-1:0]  w_alu_fun;
    logic [ADDR_WIDTH-1:0] w_addr_hold;
    logic [FUN_WIDTH-1:0]  w_fun_hold;

    assign w_cmd     = 8'(RX_P_Data);
    assign w_rx_addr = RX_P_Data[ADDR_WIDTH-1:0];
    assign w_rx_fun  = RX_P_Data[FUN_WIDTH-1:0];

    // The timer only runs while a frame is being collected
    assign w_timer_en = (r_state == ST_WR_ADDR) || (r_state == ST_WR_DATA) ||
                        (r_state == ST_RD_ADDR) || (r_state == ST_ALU_A)   ||
                        (r_state == ST_ALU_B)   || (r_state == ST_ALU_FUN);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (RX_D_VLD),
        .enable (w_timer_en),
        .expire (w_expire)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a byte always takes priority over a timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (RX_D_VLD) w_next_state = cmd_to_state(w_cmd);
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD)      w_next_state = ST_WR_DATA;
                else if (w_expire) w_next_state = ST_IDLE;
            end
            ST_WR_DATA: begin
                if (RX_D_VLD || w_expire) w_next_state = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD)      w_next_state = ST_RD_ISSUE;
                else if (w_expire) w_next_state = ST_IDLE;
            end
            ST_ALU_A: begin
                if (RX_D_VLD)      w_next_state = ST_ALU_B;
                else if (w_expire) w_next_state = ST_IDLE;
            end
            ST_ALU_B: begin
                if (RX_D_VLD)      w_next_state = ST_ALU_FUN;
                else if (w_expire) w_next_state = ST_IDLE;
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD)      w_next_state = ST_ALU_ISSUE;
                else if (w_expire) w_next_state = ST_IDLE;
            end
            // Leave once the strobe has been seen on the output register
            ST_RD_ISSUE: begin
                if (RdEn) w_next_state = ST_IDLE;
            end
            ST_ALU_ISSUE: begin
                if (ALU_En) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: computes what the output registers load at the next edge.
    // Resp_Busy is sampled in the cycle that decides the strobe, so an idle
    // response path lets the strobe appear one cycle after the last byte.
    always_comb begin
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_alu_en    = 1'b0;
        w_gate_en   = 1'b0;
        w_frame_err = 1'b0;
        w_address   = Address;
        w_wr_data   = WrData;
        w_alu_fun   = ALU_FUN;
        w_addr_hold = r_addr_hold;
        w_fun_hold  = r_fun_hold;
        case (r_state)
            ST_IDLE: begin
                if (RX_D_VLD && (cmd_to_state(w_cmd) == ST_IDLE)) w_frame_err = 1'b1;
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD)      w_addr_hold = w_rx_addr;
                else if (w_expire) w_frame_err = 1'b1;
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wr_en   = 1'b1;
                    w_address = r_addr_hold;
                    w_wr_data = RX_P_Data;
                end else if (w_expire) begin
                    w_frame_err = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_hold = w_rx_addr;
                    if (!Resp_Busy) begin
                        w_rd_en   = 1'b1;
                        w_address = w_rx_addr;
                    end
                end else if (w_expire) begin
                    w_frame_err = 1'b1;
                end
            end
            ST_ALU_A, ST_ALU_B: begin
                if (RX_D_VLD) begin
                    w_wr_en   = 1'b1;
                    w_address = (r_state == ST_ALU_A) ? c_opa_addr : c_opb_addr;
                    w_wr_data = RX_P_Data;
                end else if (w_expire) begin
                    w_frame_err = 1'b1;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    w_fun_hold = w_rx_fun;
                    w_gate_en  = 1'b1;
                    if (!Resp_Busy) begin
                        w_alu_en  = 1'b1;
                        w_alu_fun = w_rx_fun;
                    end
                end else if (w_expire) begin
                    w_frame_err = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (RX_D_VLD) w_frame_err = 1'b1;
                if (!RdEn && !Resp_Busy) begin
                    w_rd_en   = 1'b1;
                    w_address = r_addr_hold;
                end
            end
            ST_ALU_ISSUE: begin
                // Gate stays on through the strobe cycle and one cycle after
                w_gate_en = 1'b1;
                if (RX_D_VLD) w_frame_err = 1'b1;
                if (!ALU_En && !Resp_Busy) begin
                    w_alu_en  = 1'b1;
                    w_alu_fun = r_fun_hold;
                end
            end
            default: begin
                w_frame_err = 1'b0;
            end
        endcase
    end

    // Registered output stage and frame field holding registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_En      <= 1'b0;
            Gate_En     <= 1'b0;
            Frame_Err   <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_FUN     <= '0;
            r_addr_hold <= '0;
            r_fun_hold  <= '0;
        end else begin
            WrEn        <= w_wr_en;
            RdEn        <= w_rd_en;
            ALU_En      <= w_alu_en;
            Gate_En     <= w_gate_en;
            Frame_Err   <= w_frame_err;
            Address     <= w_address;
            WrData      <= w_wr_data;
            ALU_FUN     <= w_alu_fun;
            r_addr_hold <= w_addr_hold;
            r_fun_hold  <= w_fun_hold;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_frame_decoder
//  Description : Self-checking bench for cmd_frame_decoder. Frames are sent
//                as directed and random byte sequences; the expected strobe
//                list is derived from frame semantics and byte timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_decoder;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 16;

    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ALU = 3;
    localparam int K_ERR = 4;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] RX_P_Data;
    logic          RX_D_VLD;
    logic          Resp_Busy;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic          ALU_En;
    logic [FW-1:0] ALU_FUN;
    logic          Gate_En;
    logic          Frame_Err;

    cmd_frame_decoder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .FUN_WIDTH   (FW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_Data (RX_P_Data),
        .RX_D_VLD  (RX_D_VLD),
        .Resp_Busy (Resp_Busy),
        .WrEn      (WrEn),
        .RdEn      (RdEn),
        .Address   (Address),
        .WrData    (WrData),
        .ALU_En    (ALU_En),
        .ALU_FUN   (ALU_FUN),
        .Gate_En   (Gate_En),
        .Frame_Err (Frame_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int kind;
        int a;
        int d;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];

    // Register-file side of the reference: last address / data / function
    int m_addr  = 0;
    int m_wdata = 0;
    int m_fun   = 0;

    int g_cnt = 0, g_first = 0, g_last = 0;
    int e_g_cnt = 0, e_g_first = 0, e_g_last = 0;

    // Observe outputs mid-cycle and log every strobe / error / gate cycle
    always @(negedge CLK) begin
        if (WrEn)      got_q.push_back('{cyc, K_WR,  int'(Address), int'(WrData)});
        if (RdEn)      got_q.push_back('{cyc, K_RD,  int'(Address), 0});
        if (ALU_En)    got_q.push_back('{cyc, K_ALU, int'(ALU_FUN), 0});
        if (Frame_Err) got_q.push_back('{cyc, K_ERR, 0, 0});
        if (Gate_En) begin
            if (g_cnt == 0) g_first = cyc;
            g_last = cyc;
            g_cnt++;
        end
        checks++;
        assert ($countones({WrEn, RdEn, ALU_En}) <= 1) else begin
            errors++;
            $error("FAIL excl: strobes WrEn/RdEn/ALU_En=%b, required at most one high",
                   {WrEn, RdEn, ALU_En});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":WrEn"},      32'(WrEn),      0);
        check({tag, ":RdEn"},      32'(RdEn),      0);
        check({tag, ":ALU_En"},    32'(ALU_En),    0);
        check({tag, ":Gate_En"},   32'(Gate_En),   0);
        check({tag, ":Frame_Err"}, 32'(Frame_Err), 0);
        check({tag, ":Address"},   32'(Address),   0);
        check({tag, ":WrData"},    32'(WrData),    0);
        check({tag, ":ALU_FUN"},   32'(ALU_FUN),   0);
    endtask

    task automatic expect_ev(input int c, input int k, input int a, input int d);
        exp_q.push_back('{c, k, a, d});
        if (k == K_WR) begin
            m_addr  = a;
            m_wdata = d;
        end else if (k == K_RD) begin
            m_addr = a;
        end else if (k == K_ALU) begin
            m_fun = a;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Present one byte in the current cycle after 'gap' idle cycles; t = its cycle
    task automatic send_byte(input logic [7:0] b, input int gap, output int t);
        idle(gap);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        t         = cyc;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    // Last byte of a read/ALU frame with Resp_Busy high for d cycles from it
    task automatic send_last_busy(input logic [7:0] b, input int gap, input int d, output int t);
        idle(gap);
        Resp_Busy = (d > 0);
        send_byte(b, 0, t);
        if (d > 0) begin
            idle(d - 1);
            Resp_Busy = 1'b0;
        end
    endtask

    task automatic begin_seg();
        g_cnt   = 0;
        e_g_cnt = 0;
    endtask

    task automatic end_seg(input string tag);
        int n;
        idle(5);
        check({tag, ":events"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ":kind"}, got_q[i].kind, exp_q[i].kind);
            check({tag, ":cyc"},  got_q[i].cyc,  exp_q[i].cyc);
            check({tag, ":a"},    got_q[i].a,    exp_q[i].a);
            check({tag, ":d"},    got_q[i].d,    exp_q[i].d);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, ":gate_cnt"}, g_cnt, e_g_cnt);
        if (e_g_cnt > 0) begin
            check({tag, ":gate_first"}, g_first, e_g_first);
            check({tag, ":gate_last"},  g_last,  e_g_last);
        end
        check({tag, ":hold_Address"}, 32'(Address), m_addr);
        check({tag, ":hold_WrData"},  32'(WrData),  m_wdata);
        check({tag, ":hold_ALU_FUN"}, 32'(ALU_FUN), m_fun);
    endtask

    task automatic frame_wr(input logic [7:0] a, input logic [7:0] d, input int gap);
        int t;
        send_byte(8'hAA, gap, t);
        send_byte(a, gap, t);
        send_byte(d, gap, t);
        expect_ev(t + 1, K_WR, int'(a) % 16, int'(d));
    endtask

    task automatic frame_rd(input logic [7:0] a, input int gap, input int d);
        int t;
        send_byte(8'hBB, gap, t);
        send_last_busy(a, gap, d, t);
        expect_ev(t + d + 1, K_RD, int'(a) % 16, 0);
    endtask

    task automatic frame_nop(input logic [7:0] f, input int gap, input int d);
        int t;
        send_byte(8'hDD, gap, t);
        send_last_busy(f, gap, d, t);
        expect_ev(t + d + 1, K_ALU, int'(f) % 16, 0);
        e_g_cnt   = d + 2;
        e_g_first = t + 1;
        e_g_last  = t + d + 2;
    endtask

    task automatic frame_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                             input int gap, input int d);
        int t;
        send_byte(8'hCC, gap, t);
        send_byte(a, gap, t);
        expect_ev(t + 1, K_WR, 0, int'(a));
        send_byte(b, gap, t);
        expect_ev(t + 1, K_WR, 1, int'(b));
        send_last_busy(f, gap, d, t);
        expect_ev(t + d + 1, K_ALU, int'(f) % 16, 0);
        e_g_cnt   = d + 2;
        e_g_first = t + 1;
        e_g_last  = t + d + 2;
    endtask

    task automatic frame_bad(input logic [7:0] b, input int gap);
        int t;
        send_byte(b, gap, t);
        expect_ev(t + 1, K_ERR, 0, 0);
    endtask

    initial begin
        int t;
        int t1;
        logic [7:0] rb;

        RST       = 1'b0;
        RX_P_Data = '0;
        RX_D_VLD  = 1'b0;
        Resp_Busy = 1'b0;
        idle(3);
        check_all_zero("reset");
        RST = 1'b1;
        idle(2);

        // Plain write
        begin_seg();
        frame_wr(8'h05, 8'h3C, 0);
        end_seg("wr");

        // Read held off by a busy response path for 10 cycles
        begin_seg();
        frame_rd(8'h07, 0, 10);
        end_seg("rd_busy");

        // Operand writes followed by the ALU operation
        begin_seg();
        frame_alu(8'h12, 8'h34, 8'h02, 0, 0);
        end_seg("alu");

        // Unknown command, then a normal write
        begin_seg();
        frame_bad(8'h5A, 0);
        frame_wr(8'h01, 8'hFF, 1);
        end_seg("bad_cmd");

        // Silence after the address byte aborts the write
        begin_seg();
        send_byte(8'hAA, 0, t);
        send_byte(8'h03, 0, t1);
        idle(TO + 4);
        expect_ev(t1 + TO + 2, K_ERR, 0, 0);
        frame_nop(8'h04, 0, 0);
        end_seg("timeout");

        // Byte arriving in the very cycle the limit is reached still counts
        begin_seg();
        send_byte(8'hAA, 0, t);
        send_byte(8'h09, 0, t1);
        send_byte(8'h5C, TO, t);
        expect_ev(t1 + TO + 2, K_WR, 9, 8'h5C);
        end_seg("to_edge");

        // One cycle later the frame is gone and the byte is a bad command
        begin_seg();
        send_byte(8'hAA, 0, t);
        send_byte(8'h09, 0, t1);
        send_byte(8'h5C, TO + 1, t);
        expect_ev(t1 + TO + 2, K_ERR, 0, 0);
        expect_ev(t1 + TO + 3, K_ERR, 0, 0);
        end_seg("to_late");

        // Byte during a pending read is dropped without disturbing the read
        begin_seg();
        send_byte(8'hBB, 0, t);
        Resp_Busy = 1'b1;
        send_byte(8'h0A, 0, t);
        send_byte(8'h77, 0, t1);
        expect_ev(t1 + 1, K_ERR, 0, 0);
        idle(2);
        Resp_Busy = 1'b0;
        expect_ev(t + 5, K_RD, 10, 0);
        end_seg("drop");

        // Asynchronous reset between operand bytes
        begin_seg();
        send_byte(8'hCC, 0, t);
        send_byte(8'h12, 0, t);
        expect_ev(t + 1, K_WR, 0, 8'h12);
        idle(1);
        #2;
        RST = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge CLK);
        #1;
        check_all_zero("rst_hold");
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        m_addr  = 0;
        m_wdata = 0;
        m_fun   = 0;
        frame_bad(8'h34, 0);
        frame_bad(8'h02, 0);
        end_seg("reset_mid");

        // Random frames with random byte gaps and response-path stalls
        for (int i = 0; i < 40; i++) begin
            int kind;
            int gap;
            int dly;
            kind = $urandom_range(0, 4);
            gap  = $urandom_range(0, 3);
            dly  = $urandom_range(0, 3);
            begin_seg();
            case (kind)
                0: frame_wr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), gap);
                1: frame_rd(8'($urandom_range(0, 255)), gap, dly);
                2: frame_alu(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), gap, dly);
                3: frame_nop(8'($urandom_range(0, 255)), gap, dly);
                default: begin
                    rb = 8'($urandom_range(0, 255));
                    while (rb == 8'hAA || rb == 8'hBB || rb == 8'hCC || rb == 8'hDD)
                        rb = 8'($urandom_range(0, 255));
                    frame_bad(rb, gap);
                end
            endcase
            end_seg("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
